// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA timing generator: segment phases,
// default counter width and the colour-bar palette.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        BP   = 2'd1,
        ACT  = 2'd2,
        FP   = 2'd3
    } phase_t;

    localparam int CNT_W_DEF = 12;
    localparam int RGB_W     = 24;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][RGB_W-1:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            SYNC:    return BP;
            BP:      return ACT;
            ACT:     return FP;
            default: return SYNC;
        endcase
    endfunction

    function automatic bit seg_len_ok(input int len, input int w);
        return (len >= 1) && (w >= 1) && (w < 32) &&
               (longint'(len) < (longint'(1) << w));
    endfunction

endpackage

// File: rtl/vga_seg_counter.sv
// One timing axis: SYNC -> BP -> ACT -> FP phase machine with a per-segment
// counter that advances on step and wraps synchronously at the segment end.
module vga_seg_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic [CNT_W-1:0] len_sync,
    input  logic [CNT_W-1:0] len_bp,
    input  logic [CNT_W-1:0] len_act,
    input  logic [CNT_W-1:0] len_fp,
    output phase_t           phase,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    phase_t           state;
    phase_t           state_nxt;
    logic [CNT_W-1:0] seg_len;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
            count <= '0;
        end else if (step) begin
            state <= state_nxt;
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (step && last)
            state_nxt = next_phase(state);
    end

    always_comb begin
        phase = state;
        case (state)
            SYNC:    seg_len = len_sync;
            BP:      seg_len = len_bp;
            ACT:     seg_len = len_act;
            default: seg_len = len_fp;
        endcase
        last = (count == seg_len - CNT_W'(1));
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA/HDMI raster timing: registered hsync/vsync/de, active coordinates and
// line/frame strobes. Define VGA_TIMING_PATTERN_EN to add a colour-bar rgb output.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_PATTERN_EN
    ,
    output logic [RGB_W-1:0] rgb
`endif
);

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    generate
        if (!(seg_len_ok(H_SYNC, CNT_W) && seg_len_ok(H_BP, CNT_W) &&
              seg_len_ok(H_ACT, CNT_W)  && seg_len_ok(H_FP, CNT_W) &&
              seg_len_ok(V_SYNC, CNT_W) && seg_len_ok(V_BP, CNT_W) &&
              seg_len_ok(V_ACT, CNT_W)  && seg_len_ok(V_FP, CNT_W))) begin : g_bad_param
            $error("vga_timing_ctrl: segment length is zero or does not fit CNT_W");
        end
    endgenerate

    phase_t           h_phase;
    phase_t           v_phase;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_last;
    logic             v_last_unused;  // frame edges come from V phase/count instead
    logic             v_step;
    logic             sol;

    assign v_step = en && h_last && (h_phase == FP);
    assign sol    = (h_phase == SYNC) && (h_count == '0);

    vga_seg_counter #(.CNT_W(CNT_W)) u_h_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (en),
        .len_sync (CNT_W'(H_SYNC)),
        .len_bp   (CNT_W'(H_BP)),
        .len_act  (CNT_W'(H_ACT)),
        .len_fp   (CNT_W'(H_FP)),
        .phase    (h_phase),
        .count    (h_count),
        .last     (h_last)
    );

    vga_seg_counter #(.CNT_W(CNT_W)) u_v_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (v_step),
        .len_sync (CNT_W'(V_SYNC)),
        .len_bp   (CNT_W'(V_BP)),
        .len_act  (CNT_W'(V_ACT)),
        .len_fp   (CNT_W'(V_FP)),
        .phase    (v_phase),
        .count    (v_count),
        .last     (v_last_unused)
    );

`ifdef VGA_TIMING_PATTERN_EN
    // Bars are H_ACT/8 wide; anything past bar 6 (including all of a line
    // narrower than 8 pixels) falls into the last bar.
    localparam int               BAR_W     = H_ACT / 8;
    localparam logic [CNT_W-1:0] BAR_DIV_C = CNT_W'((BAR_W > 0) ? BAR_W : 1);

    logic [CNT_W-1:0] bar_q;
    logic [2:0]       bar_idx;

    always_comb begin
        bar_q   = h_count / BAR_DIV_C;
        bar_idx = 3'd7;
        if (BAR_W > 0 && bar_q < CNT_W'(7))
            bar_idx = bar_q[2:0];
    end
`endif

    // Strobes are cleared on every clk edge without en so they stay one clk wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_TIMING_PATTERN_EN
            rgb         <= '0;
`endif
        end else begin
            line_start  <= en && sol;
            frame_start <= en && sol && (v_phase == SYNC) && (v_count == '0);
            if (en) begin
                hsync <= (h_phase == SYNC) ? HS_ACT : ~HS_ACT;
                vsync <= (v_phase == SYNC) ? VS_ACT : ~VS_ACT;
                de    <= (h_phase == ACT) && (v_phase == ACT);
                x     <= (h_phase == ACT) ? h_count : '0;
                y     <= (v_phase == ACT) ? v_count : '0;
`ifdef VGA_TIMING_PATTERN_EN
                rgb   <= ((h_phase == ACT) && (v_phase == ACT)) ? BAR_RGB[bar_idx] : '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: three instances (default 640x480,
// a small raster, all-ones segments with active-high syncs).
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        hsync_a [3];
    logic        vsync_a [3];
    logic        de_a    [3];
    logic [11:0] x_a     [3];
    logic [11:0] y_a     [3];
    logic        ls_a    [3];
    logic        fs_a    [3];
`ifdef VGA_TIMING_PATTERN_EN
    logic [23:0] rgb_a   [3];
`endif

    // Per-instance geometry: default, small, all-ones.
    int hsl[3] = '{96, 4, 1};
    int hbl[3] = '{48, 3, 1};
    int hal[3] = '{640, 20, 1};
    int hfl[3] = '{16, 2, 1};
    int vsl[3] = '{2, 2, 1};
    int vbl[3] = '{33, 2, 1};
    int val[3] = '{480, 5, 1};
    int vfl[3] = '{10, 1, 1};
    bit hpol[3] = '{1'b0, 1'b0, 1'b1};
    bit vpol[3] = '{1'b0, 1'b0, 1'b1};

    int   hp[3];
    int   vp[3];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t last_exp[3];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  = 0;
    logic en_e;
    logic rst_e;

    vga_timing_ctrl dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hsync_a[0]), .vsync(vsync_a[0]),
        .de(de_a[0]), .x(x_a[0]), .y(y_a[0]), .line_start(ls_a[0]), .frame_start(fs_a[0])
`ifdef VGA_TIMING_PATTERN_EN
        , .rgb(rgb_a[0])
`endif
    );

    vga_timing_ctrl #(
        .H_SYNC(4), .H_BP(3), .H_ACT(20), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACT(5), .V_FP(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hsync_a[1]), .vsync(vsync_a[1]),
        .de(de_a[1]), .x(x_a[1]), .y(y_a[1]), .line_start(ls_a[1]), .frame_start(fs_a[1])
`ifdef VGA_TIMING_PATTERN_EN
        , .rgb(rgb_a[1])
`endif
    );

    vga_timing_ctrl #(
        .H_SYNC(1), .H_BP(1), .H_ACT(1), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACT(1), .V_FP(1),
        .HS_POL(1), .VS_POL(1)
    ) dut_o (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync(hsync_a[2]), .vsync(vsync_a[2]),
        .de(de_a[2]), .x(x_a[2]), .y(y_a[2]), .line_start(ls_a[2]), .frame_start(fs_a[2])
`ifdef VGA_TIMING_PATTERN_EN
        , .rgb(rgb_a[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout need finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int b);
        case (b)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Position-based reference: (h, v) is the raster position before the edge.
    function automatic exp_t model(input int i, input int h, input int v);
        exp_t e;
        int   h0;
        int   v0;
        int   bw;
        int   bar;
        bit   h_act;
        bit   v_act;
        h0    = hsl[i] + hbl[i];
        v0    = vsl[i] + vbl[i];
        h_act = (h >= h0) && (h < h0 + hal[i]);
        v_act = (v >= v0) && (v < v0 + val[i]);
        e.hs  = (h < hsl[i]) ? hpol[i] : !hpol[i];
        e.vs  = (v < vsl[i]) ? vpol[i] : !vpol[i];
        e.de  = h_act && v_act;
        e.x   = h_act ? 12'(h - h0) : 12'd0;
        e.y   = v_act ? 12'(v - v0) : 12'd0;
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (v == 0);
        bw    = hal[i] / 8;
        bar   = (bw == 0) ? 7 : (h - h0) / bw;
        if (bar > 7) bar = 7;
        e.rgb = e.de ? bar_colour(bar) : 24'h0;
        return e;
    endfunction

    function automatic exp_t reset_exp(input int i);
        exp_t e;
        e    = '0;
        e.hs = !hpol[i];
        e.vs = !vpol[i];
        return e;
    endfunction

    function automatic exp_t actual(input int i);
        exp_t a;
        a.hs = hsync_a[i];
        a.vs = vsync_a[i];
        a.de = de_a[i];
        a.x  = x_a[i];
        a.y  = y_a[i];
        a.ls = ls_a[i];
        a.fs = fs_a[i];
`ifdef VGA_TIMING_PATTERN_EN
        a.rgb = rgb_a[i];
`else
        a.rgb = '0;
`endif
        return a;
    endfunction

    task automatic sb_push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic sb_flush();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            hp[i] = 0;
            vp[i] = 0;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic step(input bit e);
        en = e;
        if (e && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sb_push(i, model(i, hp[i], vp[i]));
                hp[i]++;
                if (hp[i] == hsl[i] + hbl[i] + hal[i] + hfl[i]) begin
                    hp[i] = 0;
                    vp[i]++;
                    if (vp[i] == vsl[i] + vbl[i] + val[i] + vfl[i])
                        vp[i] = 0;
                end
            end
            en_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            en_e  = en;
            rst_e = rst_n;
        end
    end

    // Monitor: after every edge, compare against the queued entry (en edge),
    // the held entry with strobes low (idle edge) or the reset values.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int i = 0; i < 3; i++) begin
                    exp_t a;
                    exp_t e;
                    bit   have;
                    a    = actual(i);
                    have = 1'b1;
                    if (rst_e !== 1'b1) begin
                        e           = reset_exp(i);
                        last_exp[i] = e;
                    end else if (en_e) begin
                        if (sb_size(i) == 0) begin
                            have = 1'b0;
                            n_tests++;
                            n_fail++;
                            $display("FAIL sb_empty_%0d: got no expected entry, need 1", i);
                        end else begin
                            e           = sb_pop(i);
                            last_exp[i] = e;
                        end
                    end else begin
                        e    = last_exp[i];
                        e.ls = 1'b0;
                        e.fs = 1'b0;
                    end
                    if (have) begin
`ifndef VGA_TIMING_PATTERN_EN
                        e.rgb = '0;
`endif
                        check($sformatf("sb_out_%0d", i), 64'(a), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        int  d_hs = 0, d_vs = 0, d_de = 0, d_xmax = 0;
        int  s_vs = 0, s_de = 0, s_fs1 = -1, s_fs2 = -1;
        int  o_hs = 0, o_vs = 0, o_de = 0, o_fs1 = -1, o_fs2 = -1;
        int  b_fs1 = -1, b_fs2 = -1;
        bit  found;

        rst_n = 1'b0;
        en    = 1'b0;
        sb_flush();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_%0d", i), 64'(actual(i)), 64'(reset_exp(i)));

        // Continuous en: count segment widths and periods from the outputs.
        rst_n = 1'b1;
        for (int k = 1; k <= 28805; k++) begin
            step(1'b1);
            if (k <= 800  && hsync_a[0] == 1'b0) d_hs++;
            if (k <= 2000 && vsync_a[0] == 1'b0) d_vs++;
            if (de_a[0]) begin
                d_de++;
                if (int'(x_a[0]) > d_xmax) d_xmax = int'(x_a[0]);
`ifdef VGA_TIMING_PATTERN_EN
                if (x_a[0] == 12'd0)   check("rgb_x0",   64'(rgb_a[0]), 64'(24'hFFFFFF));
                if (x_a[0] == 12'd80)  check("rgb_x80",  64'(rgb_a[0]), 64'(24'hFFFF00));
                if (x_a[0] == 12'd639) check("rgb_x639", 64'(rgb_a[0]), 64'(24'h000000));
`endif
            end
`ifdef VGA_TIMING_PATTERN_EN
            if (k == 1) check("rgb_blank", 64'(rgb_a[0]), 64'(24'h0));
`endif
            if (k <= 290) begin
                if (vsync_a[1] == 1'b0) s_vs++;
                if (de_a[1]) s_de++;
            end
            if (fs_a[1]) begin
                if (s_fs1 < 0) s_fs1 = k;
                else if (s_fs2 < 0) s_fs2 = k;
            end
            if (k <= 16) begin
                if (hsync_a[2]) o_hs++;
                if (vsync_a[2]) o_vs++;
                if (de_a[2]) o_de++;
            end
            if (fs_a[2]) begin
                if (o_fs1 < 0) o_fs1 = k;
                else if (o_fs2 < 0) o_fs2 = k;
            end
        end
        check("d_hsync_low_per_line", 64'(d_hs), 64'(96));
        check("d_vsync_low_cycles",   64'(d_vs), 64'(1600));
        check("d_de_first_line",      64'(d_de), 64'(640));
        check("d_x_max",              64'(d_xmax), 64'(639));
        check("s_vsync_low_cycles",   64'(s_vs), 64'(58));
        check("s_de_per_frame",       64'(s_de), 64'(100));
        check("s_frame_period",       64'(s_fs2 - s_fs1), 64'(290));
        check("o_hsync_per_frame",    64'(o_hs), 64'(4));
        check("o_vsync_per_frame",    64'(o_vs), 64'(4));
        check("o_de_per_frame",       64'(o_de), 64'(1));
        check("o_frame_period",       64'(o_fs2 - o_fs1), 64'(16));

        // en asserted one clk in four: period in en cycles is unchanged.
        for (int k = 0; k < 600; k++) begin
            step(1'b1);
            if (fs_a[1]) begin
                if (b_fs1 < 0) b_fs1 = en_cnt;
                else if (b_fs2 < 0) b_fs2 = en_cnt;
            end
            repeat (3) step(1'b0);
        end
        check("s_frame_period_en", 64'(b_fs2 - b_fs1), 64'(290));

        // Asynchronous reset in the middle of an active line of the small raster.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step(1'b1);
            if (de_a[1] && x_a[1] == 12'd8) found = 1'b1;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL reset_wait: got no x=8 within 400 cycles, need x=8");
        end else begin
            #2 rst_n = 1'b0;
            #1;
            for (int i = 0; i < 3; i++)
                check($sformatf("rst_async_%0d", i), 64'(actual(i)), 64'(reset_exp(i)));
            sb_flush();
            step(1'b1);
            step(1'b1);
            rst_n = 1'b1;
            step(1'b1);
            check("restart_ls_s", 64'(ls_a[1]), 64'(1));
            check("restart_fs_s", 64'(fs_a[1]), 64'(1));
            check("restart_fs_d", 64'(fs_a[0]), 64'(1));
            check("restart_fs_o", 64'(fs_a[2]), 64'(1));
            repeat (40) step(1'b1);
        end

        step(1'b0);
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb_size(0) + sb_size(1) + sb_size(2)), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
